elevator_controller: RTL and testbench



---
 rtl/elevator_controller.sv | 162 ++++++++++++++++
 tb/tb_elevator_controller.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/elevator_controller.sv
// Six-floor SCAN elevator controller: latches cabin/hall calls, drives hoist and door.
// All outputs registered; a call sampled on edge k is acted on at edge k+1, no backpressure.
module elevator_controller #(
    parameter int BUTTONS_WIDTH = 6,
    parameter int FLOOR_CYCLES  = 4,
    parameter int DOOR_CYCLES   = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     open_btn,
    input  logic                     close_btn,
    input  logic [BUTTONS_WIDTH-1:0] btn_num_in,
    input  logic [BUTTONS_WIDTH-1:0] btn_up_out,
    input  logic [BUTTONS_WIDTH-1:0] btn_down_out,
    output logic                     engine_up,
    output logic                     engine_down,
    output logic                     open_door,
    output logic                     close_door,
    output logic [BUTTONS_WIDTH-1:0] level_display
);

    localparam int FCW = (FLOOR_CYCLES > 1) ? $clog2(FLOOR_CYCLES) : 1;
    localparam int DCW = (DOOR_CYCLES > 1) ? $clog2(DOOR_CYCLES) : 1;
    localparam logic [FCW-1:0] FLOOR_LOAD = FCW'(FLOOR_CYCLES - 1);
    localparam logic [DCW-1:0] DOOR_LOAD  = DCW'(DOOR_CYCLES - 1);

    typedef logic [BUTTONS_WIDTH-1:0] vec_t;
    typedef enum logic [1:0] {IDLE, MOVE_UP, MOVE_DOWN, DOOR_OPEN} state_t;

    state_t         state_q;
    vec_t           cab_q, cab_d, up_q, up_d, dn_q, dn_d;
    vec_t           disp_q;
    logic           dir_up_q;
    logic [FCW-1:0] move_cnt_q;
    logic [DCW-1:0] door_cnt_q;
    logic           eng_up_q, eng_dn_q, open_q, close_q;

    vec_t pending, below_m, above_m, nxt_up, nxt_dn, above_nu, below_nd, clr;
    logic here_pend, here_btn, any_above, any_below, stop_up, stop_dn;

    // The one-hot display doubles as the floor register, so all floor
    // comparisons are done with masks derived from it.
    always_comb begin
        pending   = cab_q | up_q | dn_q;
        below_m   = disp_q - vec_t'(1);
        above_m   = ~(disp_q | below_m);
        nxt_up    = disp_q << 1;
        nxt_dn    = disp_q >> 1;
        above_nu  = ~(nxt_up | (nxt_up - vec_t'(1)));
        below_nd  = nxt_dn - vec_t'(1);
        here_pend = |(pending & disp_q);
        here_btn  = |((btn_num_in | btn_up_out | btn_down_out) & disp_q);
        any_above = |(pending & above_m);
        any_below = |(pending & below_m);
        // A reverse-direction call at the arrival floor only stops the car when
        // nothing lies further ahead, which the second term already covers.
        stop_up   = (|((cab_q | up_q) & nxt_up)) || !(|(pending & above_nu));
        stop_dn   = (|((cab_q | dn_q) & nxt_dn)) || !(|(pending & below_nd));
        clr       = (state_q == DOOR_OPEN) ? disp_q : '0;
        cab_d     = (cab_q | btn_num_in)   & ~clr;
        up_d      = (up_q  | btn_up_out)   & ~clr;
        dn_d      = (dn_q  | btn_down_out) & ~clr;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            cab_q      <= '0;
            up_q       <= '0;
            dn_q       <= '0;
            disp_q     <= vec_t'(1);
            dir_up_q   <= 1'b1;
            move_cnt_q <= '0;
            door_cnt_q <= '0;
            eng_up_q   <= 1'b0;
            eng_dn_q   <= 1'b0;
            open_q     <= 1'b0;
            close_q    <= 1'b1;
        end else begin
            cab_q <= cab_d;
            up_q  <= up_d;
            dn_q  <= dn_d;
            case (state_q)
                IDLE: begin
                    if (here_pend || open_btn) begin
                        state_q    <= DOOR_OPEN;
                        door_cnt_q <= DOOR_LOAD;
                        open_q     <= 1'b1;
                        close_q    <= 1'b0;
                    end else if (dir_up_q && any_above) begin
                        state_q    <= MOVE_UP;
                        move_cnt_q <= FLOOR_LOAD;
                        eng_up_q   <= 1'b1;
                    end else if (any_below) begin
                        state_q    <= MOVE_DOWN;
                        dir_up_q   <= 1'b0;
                        move_cnt_q <= FLOOR_LOAD;
                        eng_dn_q   <= 1'b1;
                    end else if (any_above) begin
                        state_q    <= MOVE_UP;
                        dir_up_q   <= 1'b1;
                        move_cnt_q <= FLOOR_LOAD;
                        eng_up_q   <= 1'b1;
                    end
                end
                MOVE_UP: begin
                    if (move_cnt_q == '0) begin
                        disp_q <= nxt_up;
                        if (stop_up) begin
                            state_q    <= DOOR_OPEN;
                            eng_up_q   <= 1'b0;
                            open_q     <= 1'b1;
                            close_q    <= 1'b0;
                            door_cnt_q <= DOOR_LOAD;
                        end else begin
                            move_cnt_q <= FLOOR_LOAD;
                        end
                    end else begin
                        move_cnt_q <= move_cnt_q - 1'b1;
                    end
                end
                MOVE_DOWN: begin
                    if (move_cnt_q == '0) begin
                        disp_q <= nxt_dn;
                        if (stop_dn) begin
                            state_q    <= DOOR_OPEN;
                            eng_dn_q   <= 1'b0;
                            open_q     <= 1'b1;
                            close_q    <= 1'b0;
                            door_cnt_q <= DOOR_LOAD;
                        end else begin
                            move_cnt_q <= FLOOR_LOAD;
                        end
                    end else begin
                        move_cnt_q <= move_cnt_q - 1'b1;
                    end
                end
                DOOR_OPEN: begin
                    // Any reopen request outranks close_btn.
                    if (open_btn || here_btn) begin
                        door_cnt_q <= DOOR_LOAD;
                    end else if (close_btn || door_cnt_q == '0) begin
                        state_q    <= IDLE;
                        door_cnt_q <= '0;
                        open_q     <= 1'b0;
                        close_q    <= 1'b1;
                    end else begin
                        door_cnt_q <= door_cnt_q - 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign engine_up     = eng_up_q;
    assign engine_down   = eng_dn_q;
    assign open_door     = open_q;
    assign close_door    = close_q;
    assign level_display = disp_q;

endmodule

// File: tb/tb_elevator_controller.sv
// Directed bench for elevator_controller: trips, door timing, reset mid-move.
module tb_elevator_controller;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       open_btn = 1'b0;
    logic       close_btn = 1'b0;
    logic [5:0] btn_num_in = '0;
    logic [5:0] btn_up_out = '0;
    logic [5:0] btn_down_out = '0;
    logic       engine_up, engine_down, open_door, close_door;
    logic [5:0] level_display;

    elevator_controller #(
        .BUTTONS_WIDTH(6),
        .FLOOR_CYCLES (4),
        .DOOR_CYCLES  (8)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .open_btn     (open_btn),
        .close_btn    (close_btn),
        .btn_num_in   (btn_num_in),
        .btn_up_out   (btn_up_out),
        .btn_down_out (btn_down_out),
        .engine_up    (engine_up),
        .engine_down  (engine_down),
        .open_door    (open_door),
        .close_door   (close_door),
        .level_display(level_display)
    );

    always #5 clk = ~clk;

    int         tests_run = 0;
    int         tests_failed = 0;
    int         up_cnt, dn_cnt, n;
    logic       both_seen;
    logic [5:0] disp_at [0:63];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        open_btn = 1'b0; close_btn = 1'b0;
        btn_num_in = '0; btn_up_out = '0; btn_down_out = '0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Samples at negedges until the door opens, counting engine cycles and
    // recording the display at each engine cycle count.
    task automatic travel(input string tag, input int inject_open_at);
        int cyc;
        up_cnt = 0; dn_cnt = 0; both_seen = 1'b0; cyc = 0;
        while (!open_door && cyc < 200) begin
            if (engine_up && engine_down) both_seen = 1'b1;
            if (engine_up) up_cnt++;
            if (engine_down) dn_cnt++;
            if (up_cnt + dn_cnt < 64) disp_at[up_cnt + dn_cnt] = level_display;
            open_btn = (engine_up || engine_down) && (up_cnt + dn_cnt == inject_open_at);
            @(negedge clk);
            cyc++;
        end
        open_btn = 1'b0;
        chk({tag, "_door_reached"}, open_door, 1'b1);
        chk({tag, "_never_both"}, both_seen, 1'b0);
        chk({tag, "_engine_off_at_stop"}, {engine_up, engine_down}, 2'b00);
    endtask

    task automatic door_len(output int cnt);
        cnt = 0;
        while (open_door && cnt < 100) begin
            cnt++;
            @(negedge clk);
        end
    endtask

    initial begin
        // Reset state
        do_reset();
        repeat (3) @(negedge clk);
        chk("rst_display", level_display, 6'b000001);
        chk("rst_close", close_door, 1'b1);
        chk("rst_open", open_door, 1'b0);
        chk("rst_eng_up", engine_up, 1'b0);
        chk("rst_eng_dn", engine_down, 1'b0);

        // Floor 0 -> 3
        btn_num_in = 6'b001000;
        @(negedge clk);
        btn_num_in = '0;
        chk("t2_latch_only", engine_up, 1'b0);
        travel("t2", 0);
        chk("t2_up_cycles", up_cnt, 12);
        chk("t2_dn_cycles", dn_cnt, 0);
        chk("t2_disp_c4", disp_at[4], 6'b000001);
        chk("t2_disp_c5", disp_at[5], 6'b000010);
        chk("t2_disp_c9", disp_at[9], 6'b000100);
        chk("t2_disp_stop", level_display, 6'b001000);
        door_len(n);
        chk("t2_door_len", n, 8);
        chk("t2_close", close_door, 1'b1);
        repeat (3) @(negedge clk);
        chk("t2_idle", {open_door, engine_up, engine_down}, 3'b000);

        // Cabin 4 + hall down 2: pass 2 going up, collect it coming down
        do_reset();
        btn_num_in = 6'b010000;
        btn_down_out = 6'b000100;
        @(negedge clk);
        btn_num_in = '0; btn_down_out = '0;
        travel("t3a", 0);
        chk("t3_up_cycles", up_cnt, 16);
        chk("t3_disp_4", level_display, 6'b010000);
        door_len(n);
        chk("t3_door4_len", n, 8);
        travel("t3b", 0);
        chk("t3_dn_cycles", dn_cnt, 8);
        chk("t3_up_none", up_cnt, 0);
        chk("t3_disp_2", level_display, 6'b000100);
        door_len(n);
        chk("t3_door2_len", n, 8);
        repeat (4) @(negedge clk);
        chk("t3_down2_cleared", {open_door, engine_up, engine_down}, 3'b000);

        // Hall call at the current floor, close early, then open+close reload
        btn_up_out = 6'b000100;
        @(negedge clk);
        btn_up_out = '0;
        chk("t4_latch_only", open_door, 1'b0);
        @(negedge clk);
        chk("t4_open_next", open_door, 1'b1);
        chk("t4_no_engine", {engine_up, engine_down}, 2'b00);
        @(negedge clk);
        chk("t4_open_c2", open_door, 1'b1);
        close_btn = 1'b1;
        @(negedge clk);
        close_btn = 1'b0;
        chk("t4_close_early", close_door, 1'b1);
        chk("t4_open_low", open_door, 1'b0);
        repeat (2) @(negedge clk);
        chk("t4_up2_cleared", open_door, 1'b0);
        open_btn = 1'b1;
        @(negedge clk);
        open_btn = 1'b0;
        chk("t4_open_btn_idle", open_door, 1'b1);
        repeat (3) @(negedge clk);
        open_btn = 1'b1;
        close_btn = 1'b1;
        @(negedge clk);
        open_btn = 1'b0;
        close_btn = 1'b0;
        chk("t4_both_keep_open", open_door, 1'b1);
        door_len(n);
        chk("t4_reload_len", n, 8);

        // Reset while moving between floors 2 and 3
        do_reset();
        btn_num_in = 6'b100000;
        @(negedge clk);
        btn_num_in = '0;
        up_cnt = 0;
        for (int g = 0; g < 100 && up_cnt < 10; g++) begin
            @(negedge clk);
            if (engine_up) up_cnt++;
        end
        chk("t5_mid_floor2", level_display, 6'b000100);
        #1 reset = 1'b1;
        #1;
        chk("t5_rst_eng", {engine_up, engine_down}, 2'b00);
        chk("t5_rst_disp", level_display, 6'b000001);
        chk("t5_rst_doors", {open_door, close_door}, 2'b01);
        @(negedge clk);
        reset = 1'b0;
        up_cnt = 0;
        for (int g = 0; g < 12; g++) begin
            @(negedge clk);
            if (engine_up || engine_down || open_door) up_cnt++;
        end
        chk("t5_request_lost", up_cnt, 0);

        // open_btn during motion is ignored
        do_reset();
        btn_num_in = 6'b000100;
        @(negedge clk);
        btn_num_in = '0;
        travel("t6", 3);
        chk("t6_up_cycles", up_cnt, 8);
        chk("t6_disp", level_display, 6'b000100);
        door_len(n);
        chk("t6_door_len", n, 8);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
